// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM state encoding and the default reset PC.
// States are plain logic constants so legacy include-based code can reuse them.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t S_REQ  = 3'd0;
   localparam fetch_state_t S_WAIT = 3'd1;
   localparam fetch_state_t S_HOLD = 3'd2;
   localparam fetch_state_t S_EXEC = 3'd3;
   localparam fetch_state_t S_HALT = 3'd4;

endpackage

// File: rtl/fetch_unit.sv
// Single-issue fetch FSM owning the PC: request -> response -> decode handshake -> commit, 4-cycle minimum loop.
// Stalls in place on imem_req_ready/inst_ready low; at most one instruction in flight.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_load,
   input  logic [31:0]        next_pc,
   input  logic               halt_req,
   input  logic               resume,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [31:0]        imem_addr,
   input  logic               imem_resp_valid,
   input  logic [31:0]        imem_resp_data,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [31:0]        inst,
   output logic [31:0]        inst_pc,
   output logic               halted,
   output logic [COUNT_W-1:0] fetch_count
);

   fetch_state_t state;
   logic [31:0]  pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         inst        <= 32'h0;
         inst_pc     <= 32'h0;
         fetch_count <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req_ready) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  inst    <= imem_resp_data;
                  inst_pc <= pc;
                  state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  fetch_count <= fetch_count + COUNT_W'(1);
                  state       <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (pc_load) begin
                  pc    <= next_pc;
                  state <= halt_req ? S_HALT : S_REQ;
               end
            end
            S_HALT: begin
               // pc_load is deliberately not examined here: resume always wins
               if (resume) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   assign imem_req_valid = (state == S_REQ);
   assign imem_addr      = pc;
   assign inst_valid     = (state == S_HOLD);
   assign halted         = (state == S_HALT);

endmodule
